// File: rtl/if_prefetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg: shared widths, constants and types for the instruction-fetch
// prefetch queue.
//   XLEN          - architectural address width (PC width)
//   ILEN          - instruction word width
//   INSTR_NOP     - canonical no-op encoding (addi x0, x0, 0)
//   fetch_entry_t - one buffered fetch result {pc, instr}
//   align_pc()    - clears the two low PC bits (word-aligned fetch)
// -----------------------------------------------------------------------------
package if_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// -----------------------------------------------------------------------------
// if_prefetch_queue_if: bundle of every non-clock/reset signal of the fetch
// front end.
//   redirect_valid/redirect_pc        - EX-stage taken branch / jump
//   imem_req_valid/ready/addr         - in-order fetch request channel
//   imem_resp_valid/data              - in-order response, no backpressure
//   out_valid/ready/pc/instr          - head of the buffered fetch stream
// Modports:
//   master - the fetch unit (drives requests and the output stream)
//   slave  - the surroundings (memory, hazard unit, EX redirect)
// -----------------------------------------------------------------------------
interface if_prefetch_queue_if;
    import if_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;

    logic            imem_resp_valid;
    logic [ILEN-1:0] imem_resp_data;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  out_ready,
        output imem_req_valid, imem_req_addr,
        output out_valid, out_pc, out_instr
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output out_ready,
        input  imem_req_valid, imem_req_addr,
        input  out_valid, out_pc, out_instr
    );

endinterface

// File: rtl/if_prefetch_queue_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst - clock, synchronous active-high reset (empties the FIFO)
//   push/din - write din at the tail
//   pop      - drop the head (ignored while empty)
//   clear    - empty the FIFO this cycle; wins over push and pop
//   dout     - current head (stale contents while empty)
//   full, empty, count - occupancy
// Push and pop in the same cycle both take effect, also when full: the freed
// head slot is the one being written, and the head is read before the edge.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths also work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~clear;
    assign do_pop  = pop & ~empty & ~clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(do_push && full && !do_pop));

endmodule

// File: rtl/if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// if_prefetch_queue: instruction-fetch front end.
// Owns the PC, issues in-order word fetches to a variable-latency instruction
// memory and buffers the returned {pc, instr} pairs for the IF/ID register.
//   clk, rst      - clock, synchronous active-high reset
//   bus (master)  - redirect, imem request/response and output stream
// Parameters: RESET_PC (first fetch address), DEPTH (buffer entries),
// MAX_OUTSTANDING (requests awaiting a response, kept + dropped).
//
// Credit scheme: a request is only issued when the buffer has a slot for its
// response (count + live < DEPTH), so responses never need backpressure.
// A redirect turns every pending response into a "discard" credit; since the
// memory answers in order, the next `discard` responses are the stale ones.
// Issued PCs travel through a small tag queue and are re-joined with their
// instruction word when the response arrives.
// -----------------------------------------------------------------------------
module if_prefetch_queue
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst,
    if_prefetch_queue_if.master bus
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [OW-1:0]   live_q, live_d;
    logic [OW-1:0]   discard_q, discard_d;

    logic            credit_ok;
    logic            req_fire;
    logic            resp_keep;
    logic            out_pop;

    logic [XLEN-1:0] tag_head;
    logic            tag_full, tag_empty;
    logic [OW-1:0]   tag_count;

    fetch_entry_t    fifo_din, fifo_head;
    logic            fifo_full, fifo_empty;
    logic [FW-1:0]   fifo_count;

    // ------------------------------------------------------------------
    // Request / response handshakes (combinational outputs)
    // ------------------------------------------------------------------
    assign credit_ok = (32'(fifo_count) + 32'(live_q) < DEPTH) &&
                       (32'(live_q) + 32'(discard_q) < MAX_OUTSTANDING);

    assign bus.imem_req_valid = ~rst & ~bus.redirect_valid & credit_ok;
    assign bus.imem_req_addr  = pc_q;
    assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;

    // Stale responses are drained first, so a response is kept only once
    // every discard credit has been used up.
    assign resp_keep = bus.imem_resp_valid & (discard_q == '0);

    assign bus.out_valid = ~fifo_empty & ~bus.redirect_valid;
    assign out_pop       = bus.out_valid & bus.out_ready;
    assign bus.out_pc    = fifo_empty ? '0 : fifo_head.pc;
    assign bus.out_instr = fifo_empty ? '0 : fifo_head.instr;

    assign fifo_din = {tag_head, bus.imem_resp_data};

    // ------------------------------------------------------------------
    // PC and credit counters
    // ------------------------------------------------------------------
    always_comb begin
        pc_d      = pc_q;
        live_d    = live_q;
        discard_d = discard_q;
        if (bus.redirect_valid) begin
            // Everything still in flight becomes stale; a response arriving
            // this very cycle has already consumed its credit.
            pc_d      = align_pc(bus.redirect_pc);
            discard_d = discard_q + live_q - OW'(bus.imem_resp_valid);
            live_d    = '0;
        end else begin
            if (req_fire) pc_d = pc_q + XLEN'(4);
            live_d    = live_q + OW'(req_fire) - OW'(resp_keep);
            discard_d = discard_q - OW'(bus.imem_resp_valid & ~resp_keep);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            live_q    <= '0;
            discard_q <= '0;
        end else begin
            pc_q      <= pc_d;
            live_q    <= live_d;
            discard_q <= discard_d;
        end
    end

    // ------------------------------------------------------------------
    // PC tag queue: one entry per outstanding request (kept or stale).
    // Never cleared by redirect, stale tags drain with their responses.
    // ------------------------------------------------------------------
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (bus.imem_resp_valid),
        .clear (1'b0),
        .din   (pc_q),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    // ------------------------------------------------------------------
    // Instruction buffer
    // ------------------------------------------------------------------
    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk   (clk),
        .rst   (rst),
        .push  (resp_keep & ~bus.redirect_valid),
        .pop   (out_pop),
        .clear (bus.redirect_valid),
        .din   (fifo_din),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_outstanding_bound: assert property (@(posedge clk) disable iff (rst)
        32'(live_q) + 32'(discard_q) <= MAX_OUTSTANDING);
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        32'(fifo_count) <= DEPTH);
    a_tags_match_credits: assert property (@(posedge clk) disable iff (rst)
        32'(tag_count) == 32'(live_q) + 32'(discard_q));
    a_no_spurious_resp: assert property (@(posedge clk) disable iff (rst)
        bus.imem_resp_valid |-> !tag_empty);
    a_tag_space: assert property (@(posedge clk) disable iff (rst)
        req_fire |-> !tag_full);
    a_buffer_space: assert property (@(posedge clk) disable iff (rst)
        (resp_keep && !bus.redirect_valid && !out_pop) |-> !fifo_full);

endmodule

// File: tb/tb_if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// Bench for if_prefetch_queue. A behavioural memory hands back in-order
// responses after a chosen latency; a reference model tracks the expected
// request address stream and the ordered list of buffered {pc, instr} pairs,
// with stale responses recognised by the path epoch they were issued on.
// -----------------------------------------------------------------------------
module tb_if_prefetch_queue;
    import if_pkg::*;

    localparam int              DEPTH    = 4;
    localparam int              MAX_OUT  = 4;
    localparam logic [XLEN-1:0] RESET_PC = 64'h0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_prefetch_queue_if bus ();

    if_prefetch_queue #(
        .RESET_PC        (RESET_PC),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          due;
        logic [63:0] addr;
        logic [31:0] data;
        int          ep;
    } mreq_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        bit          rdr;
        logic [63:0] rpc;
        bit          e_rv;
        logic [63:0] e_ra;
        bit          e_ov;
        logic [63:0] e_op;
    } vec_t;

    mreq_t       mq[$];      // requests accepted by the memory, oldest first
    ent_t        bq[$];      // what the fetch buffer should hold, head first
    logic [63:0] popped[$];  // pcs actually handed over to IF/ID
    logic [63:0] m_req_pc;
    int          epoch, cyc, last_due;
    int          lat_min, lat_max, rdy_pct;
    int          n_cmp, n_bad;

    logic        c_rst, c_rdr, c_ordy;
    logic [63:0] c_rpc;
    logic        s_rv, s_ov, s_rdy;
    logic [63:0] s_ra, s_op;
    logic [31:0] s_oi;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, update
    // the model with what happens at the coming edge.
    task automatic step();
        bit have_resp, e_rv, e_ov, rdy;
        int live, lat, due;
        mreq_t r;
        have_resp = !c_rst && mq.size() > 0 && mq[0].due == cyc;
        rdy       = ($urandom_range(99) < rdy_pct);
        rst                 = c_rst;
        bus.redirect_valid  = c_rdr;
        bus.redirect_pc     = c_rpc;
        bus.out_ready       = c_ordy;
        bus.imem_req_ready  = rdy;
        bus.imem_resp_valid = have_resp;
        bus.imem_resp_data  = have_resp ? mq[0].data : $urandom;
        #1;
        s_rv = bus.imem_req_valid; s_ra = bus.imem_req_addr; s_rdy = rdy;
        s_ov = bus.out_valid; s_op = bus.out_pc; s_oi = bus.out_instr;

        live = 0;
        foreach (mq[i]) if (mq[i].ep == epoch) live++;
        e_rv = !c_rst && !c_rdr && (bq.size() + live < DEPTH) && (mq.size() < MAX_OUT);
        e_ov = (bq.size() > 0) && !c_rdr;
        chk("req_valid", s_rv, e_rv);
        if (e_rv) chk("req_addr", s_ra, m_req_pc);
        chk("out_valid", s_ov, e_ov);
        if (e_ov && s_ov) begin
            chk("out_pc", s_op, bq[0].pc);
            chk("out_instr", 64'(s_oi), 64'(bq[0].instr));
        end

        if (s_ov && c_ordy) popped.push_back(s_op);
        if (e_ov && c_ordy) void'(bq.pop_front());
        if (have_resp) begin
            if (!c_rdr && mq[0].ep == epoch)
                bq.push_back('{mq[0].addr, mq[0].data});
            void'(mq.pop_front());
        end
        if (e_rv && rdy) begin
            lat = $urandom_range(lat_max, lat_min);
            due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = due;
            r.due = due; r.addr = m_req_pc; r.data = $urandom; r.ep = epoch;
            mq.push_back(r);
            m_req_pc = m_req_pc + 64'd4;
        end
        if (c_rdr) begin
            bq.delete();
            epoch++;
            m_req_pc = c_rpc & ~64'h3;
        end
        if (c_rst) begin
            bq.delete();
            mq.delete();
            epoch++;
            m_req_pc = RESET_PC;
            last_due = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        c_rst = 1'b1;
        c_rdr = 1'b0;
        repeat (n) step();
        c_rst = 1'b0;
    endtask

    vec_t tbl[11];

    initial begin
        bit found;
        n_cmp = 0; n_bad = 0; cyc = 0; epoch = 0; last_due = 0;
        lat_min = 1; lat_max = 1; rdy_pct = 100;
        m_req_pc = RESET_PC;
        c_rst = 1'b1; c_rdr = 1'b0; c_ordy = 1'b1; c_rpc = '0;
        rst = 1'b1;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        bus.imem_req_ready = 1'b1; bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data = '0;   bus.out_ready = 1'b1;

        // Zero-wait memory from reset release, then a redirect to 0x203
        // that coincides with the response for 0x14.
        //            rdr  rpc         rv  ra         ov  op
        tbl[0]  = '{0, 64'h0,   1, 64'h0,   0, 64'h0};
        tbl[1]  = '{0, 64'h0,   1, 64'h4,   0, 64'h0};
        tbl[2]  = '{0, 64'h0,   1, 64'h8,   1, 64'h0};
        tbl[3]  = '{0, 64'h0,   1, 64'hC,   1, 64'h4};
        tbl[4]  = '{0, 64'h0,   1, 64'h10,  1, 64'h8};
        tbl[5]  = '{0, 64'h0,   1, 64'h14,  1, 64'hC};
        tbl[6]  = '{1, 64'h203, 0, 64'h0,   0, 64'h0};
        tbl[7]  = '{0, 64'h0,   1, 64'h200, 0, 64'h0};
        tbl[8]  = '{0, 64'h0,   1, 64'h204, 0, 64'h0};
        tbl[9]  = '{0, 64'h0,   1, 64'h208, 1, 64'h200};
        tbl[10] = '{0, 64'h0,   1, 64'h20C, 1, 64'h204};

        repeat (2) @(posedge clk);
        #1;

        // Reset state
        step();
        chk("rst_out_valid", s_ov, 0);
        chk("rst_req_valid", s_rv, 0);
        chk("rst_out_pc", s_op, 0);
        chk("rst_out_instr", 64'(s_oi), 0);
        c_rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            c_rdr = tbl[i].rdr;
            c_rpc = tbl[i].rpc;
            step();
            chk($sformatf("tbl%0d_req_valid", i), s_rv, tbl[i].e_rv);
            if (tbl[i].e_rv) chk($sformatf("tbl%0d_req_addr", i), s_ra, tbl[i].e_ra);
            chk($sformatf("tbl%0d_out_valid", i), s_ov, tbl[i].e_ov);
            if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_pc", i), s_op, tbl[i].e_op);
        end
        c_rdr = 1'b0;

        // IF/ID stalled: only DEPTH requests go out, head holds pc 0.
        do_reset(2);
        c_ordy = 1'b0;
        begin
            int nf = 0;
            repeat (10) begin
                step();
                if (s_rv && s_rdy) nf++;
            end
            chk("stall_req_count", 64'(nf), 64'(DEPTH));
        end
        chk("stall_req_valid_low", s_rv, 0);
        chk("stall_head_pc", s_op, 64'h0);
        popped.delete();
        c_ordy = 1'b1;
        repeat (5) step();
        chk("stall_release_pops", 64'(popped.size()), 5);
        if (popped.size() == 5)
            for (int i = 0; i < 5; i++)
                chk($sformatf("stall_release_pc%0d", i), popped[i], 64'(4 * i));

        // Latency 3: redirect to 0x100 right after the request for 0xC.
        do_reset(2);
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (s_rv && s_rdy && s_ra == 64'hC) found = 1;
        end
        chk("lat3_fire_c", found, 1);
        popped.delete();
        c_rdr = 1'b1; c_rpc = 64'h100;
        step();
        c_rdr = 1'b0;
        for (int k = 0; k < 30 && popped.size() < 2; k++) step();
        chk("lat3_pops", 64'(popped.size() >= 2), 1);
        if (popped.size() >= 2) begin
            chk("lat3_first_pc", popped[0], 64'h100);
            chk("lat3_second_pc", popped[1], 64'h104);
        end

        // Back-to-back redirects: only the second path is ever delivered.
        do_reset(2);
        lat_min = 2; lat_max = 2;
        repeat (6) step();
        c_rdr = 1'b1; c_rpc = 64'h40;
        step();
        c_rpc = 64'h80;
        step();
        c_rdr = 1'b0;
        popped.delete();
        for (int k = 0; k < 30 && popped.size() < 3; k++) step();
        chk("b2b_pops", 64'(popped.size() >= 3), 1);
        if (popped.size() >= 3)
            for (int i = 0; i < 3; i++)
                chk($sformatf("b2b_pc%0d", i), popped[i], 64'h80 + 64'(4 * i));
        repeat (4) step();
        chk("b2b_discard_zero", 64'(dut.discard_q), 0);

        // Reset with a full buffer.
        do_reset(2);
        lat_min = 1; lat_max = 1;
        c_ordy = 1'b0;
        repeat (8) step();
        chk("full_before_rst", s_ov, 1);
        c_rst = 1'b1;
        step();
        step();
        chk("rstfull_out_valid", s_ov, 0);
        chk("rstfull_req_valid", s_rv, 0);
        c_rst = 1'b0; c_ordy = 1'b1;
        step();
        chk("rstfull_restart_valid", s_rv, 1);
        chk("rstfull_restart_addr", s_ra, RESET_PC);
        popped.delete();
        repeat (3) step();
        chk("rstfull_first_pop", 64'(popped.size() > 0 ? popped[0] : 64'hDEAD), RESET_PC);

        // Randomised traffic against the model.
        lat_min = 1; lat_max = 5; rdy_pct = 70;
        popped.delete();
        for (int k = 0; k < 2000; k++) begin
            c_rst  = ($urandom_range(199) == 0);
            c_rdr  = !c_rst && ($urandom_range(99) < 4);
            c_rpc  = {$urandom, $urandom};
            c_ordy = ($urandom_range(99) < 75);
            step();
        end
        c_rst = 1'b0; c_rdr = 1'b0;
        chk("random_progress", 64'(popped.size() > 100), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
